ringbuffer_ctrl: RTL
====================

# ringbuffer_ctrl

Clocked, parametrised pointer/occupancy controller for a power-of-two ring buffer whose storage is an external dual-port RAM. The producer writes RAM at `write_addr` and pulses `write_done`; the consumer reads RAM at `read_addr` and pulses `read_done`. The block is the synchronous successor of the strobe-driven ringbuffer. It adds:
- a fill level and almost-full threshold,
- selectable drop-new / overwrite-oldest overflow modes,
- sticky overflow/underflow flags and a drop counter,
- a synchronous flush.

## Interface
Parameters:
- `BITS`, 7, address width; depth is 2^BITS entries, all usable.
- `AFULL_LEVEL`, 2^BITS-8, almost_full threshold; legal range 1..2^BITS.
- `OVERWRITE`, 0, 0 = drop new writes when full; 1 = overwrite the oldest entry when full.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `write_done`  in  1  one entry written at current `write_addr` this cycle; level-sampled each cycle.
- `read_done`  in  1  entry at current `read_addr` consumed this cycle.
- `clear`  in  1  synchronous flush.
- `write_addr`  out  BITS  next slot to write.
- `read_addr`  out  BITS  oldest valid entry.
- `level`  out  BITS+1  number of valid entries, 0..2^BITS.
- `empty`  out  1  level == 0.
- `full`  out  1  level == 2^BITS.
- `almost_full`  out  1  level >= AFULL_LEVEL.
- `overflow`  out  1  sticky: a write arrived while full with no simultaneous read.
- `underflow`  out  1  sticky: a read arrived while empty.
- `drop_count`  out  8  count of overflow events, saturating at 255.

## Operation
Reset state (reset low, asynchronous): write_addr=0, read_addr=0, level=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, drop_count=0.

Output derivation:
- empty, full and almost_full are decoded from the level register only.
- No combinational path from any input to any output.

Per-cycle priority:
1. clear=1: same values as reset (including sticky flags and drop_count). Strobes in that cycle are ignored.
2. Otherwise, let W=write_done and R=read_done, evaluated against the current level.

Cases:
- W only, not full: write_addr+1 (mod 2^BITS); level+1.
- W only, full, OVERWRITE=0: pointers and level unchanged; overflow←1; drop_count+1 (saturating).
- W only, full, OVERWRITE=1: write_addr+1 and read_addr+1, discarding the oldest entry; level unchanged; overflow←1; drop_count+1 (saturating).
- R only, not empty: read_addr+1; level−1.
- R only, empty: no pointer/level change; underflow←1.
- W and R, 0<level<2^BITS: both pointers +1; level unchanged.
- W and R, empty: write accepted (write_addr+1, level=1); read rejected; underflow←1.
- W and R, full, either mode: both pointers +1; level unchanged; no overflow, no drop_count change.

Pointer and level rules:
- Pointers wrap naturally from 2^BITS−1 to 0.
- level is BITS+1 bits wide and never leaves 0..2^BITS.
- write_addr == read_addr is ambiguous; only level distinguishes empty from full.

## Timing
- Latency: every output reflects a strobe one clock after the edge that samples it.
- Strobes may be held high on consecutive cycles; each high cycle is one event (streaming one entry per clock).
- Producer must present RAM data in the same cycle as write_done at the pre-edge write_addr.
- Consumer must capture RAM data at the pre-edge read_addr no later than the cycle it asserts read_done.
- Reset asserted mid-stream: outputs go to reset values immediately, without waiting for a clock. Deassertion is synchronised externally. The first strobe is honoured on the first clock edge after deassertion.
- Sticky flags and drop_count clear only by reset or clear.

## Test plan
- BITS=7: reset, then one write, then one read on successive clocks → write_addr=1, read_addr=1, level=0, empty=1, full=0, overflow=0.
- BITS=3, OVERWRITE=0, AFULL_LEVEL=6: 6 writes → almost_full=1, level=6. 2 more writes → full=1, write_addr=0. 3 more writes → level=8, read_addr=0, overflow=1, drop_count=3.
- BITS=3, OVERWRITE=1: fill to 8, then 2 writes → level=8, write_addr=2, read_addr=2, drop_count=2. Then 8 reads → empty=1, read_addr=2.
- BITS=3: level=8, then W and R in the same cycle → level=8, both pointers +1, overflow=0. Then with empty, W and R in the same cycle → level=1, underflow=1, read_addr unchanged.
- BITS=3: 300 writes while full, OVERWRITE=0 → drop_count=255. Then clear together with write_done → all reset values, write_addr=0.
- BITS=7: 5 writes, then assert reset between clock edges → outputs return to reset values before the next edge. After deassertion, 1 write → write_addr=1.

Source files
------------

// File: rtl/ringbuffer_ctrl.sv
// Pointer and occupancy controller for a power-of-two ring buffer held in external dual-port RAM.
// Tracks write/read pointers and a fill level, with selectable overflow handling and sticky error status.
module ringbuffer_ctrl #(
    parameter int BITS        = 7,
    parameter int AFULL_LEVEL = (1 << BITS) - 8,
    parameter bit OVERWRITE   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write_done,
    input  logic            read_done,
    input  logic            clear,
    output logic [BITS-1:0] write_addr,
    output logic [BITS-1:0] read_addr,
    output logic [BITS:0]   level,
    output logic            empty,
    output logic            full,
    output logic            almost_full,
    output logic            overflow,
    output logic            underflow,
    output logic [7:0]      drop_count
);

    localparam logic [BITS:0]   DEPTH     = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0]   AFULL_THR = (BITS+1)'(AFULL_LEVEL);
    localparam logic [BITS-1:0] PTR_ONE   = BITS'(1);
    localparam logic [BITS:0]   LVL_ONE   = (BITS+1)'(1);

    logic [BITS-1:0] wptr_q, wptr_d;
    logic [BITS-1:0] rptr_q, rptr_d;
    logic [BITS:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [7:0]      drop_q, drop_d;
    logic            is_full, is_empty;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign is_full  = (level_q == DEPTH);
    assign is_empty = (level_q == '0);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        drop_d  = drop_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            unique case ({write_done, read_done})
                2'b10: begin
                    if (!is_full) begin
                        wptr_d  = wptr_q + PTR_ONE;
                        level_d = level_q + LVL_ONE;
                    end else begin
                        ovf_d  = 1'b1;
                        drop_d = sat_inc(drop_q);
                        // Overwrite mode sacrifices the oldest entry so the level stays pinned at full.
                        if (OVERWRITE) begin
                            wptr_d = wptr_q + PTR_ONE;
                            rptr_d = rptr_q + PTR_ONE;
                        end
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        rptr_d  = rptr_q + PTR_ONE;
                        level_d = level_q - LVL_ONE;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                2'b11: begin
                    // Empty: the write lands but there was nothing for the read to consume.
                    wptr_d = wptr_q + PTR_ONE;
                    if (is_empty) begin
                        level_d = LVL_ONE;
                        unf_d   = 1'b1;
                    end else begin
                        rptr_d = rptr_q + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            drop_q  <= drop_d;
        end
    end

    assign write_addr  = wptr_q;
    assign read_addr   = rptr_q;
    assign level       = level_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (level_q >= AFULL_THR);
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign drop_count  = drop_q;

endmodule
